// File: rtl/wsp_controller.sv
// ---------------------------------------------------------------------------
// wsp_controller
//
// Purpose:
//   Wrapper serial port (WSP) controller for a core test wrapper. It holds the
//   wrapper instruction register (WIR) as a shift stage plus an update stage,
//   decodes the active instruction into boundary-register (WBR) cell
//   configuration, owns the one-bit wrapper bypass register (WBY), gates the
//   WSP strobes onto the WBR cell controls, tracks data-register activity
//   with a small FSM and shift counter, and flags WSP protocol violations.
//
// Parameters:
//   WIR_W  - WIR length in bits (3 or more)
//   CNT_W  - width of the data-register shift counter
//
// Ports:
//   clk          in   single clock, rising edge
//   arst         in   asynchronous active-high reset
//   wsi          in   wrapper serial input
//   select_wir   in   1 = WIR path, 0 = data-register path
//   capture_wr   in   WSP capture strobe
//   shift_wr     in   WSP shift strobe
//   update_wr    in   WSP update strobe
//   transfer_dr  in   WBR transfer strobe
//   wbr_so       in   serial return from the WBR chain
//   wso          out  wrapper serial output
//   wbr_si       out  serial feed into the WBR chain (equals wsi)
//   capture/shift/update/transfer  out  WBR cell controls
//   mode/io_face/safe              out  WBR cell configuration
//   wby_sel/wbr_sel                out  active data register
//   instr        out  active (update-stage) instruction
//   shift_cnt    out  data-register shifts since the last capture (saturating)
//   proto_err    out  sticky protocol-violation flag
// ---------------------------------------------------------------------------
module wsp_controller #(
  parameter int WIR_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             wsi,
  input  logic             select_wir,
  input  logic             capture_wr,
  input  logic             shift_wr,
  input  logic             update_wr,
  input  logic             transfer_dr,
  input  logic             wbr_so,
  output logic             wso,
  output logic             wbr_si,
  output logic             capture,
  output logic             shift,
  output logic             update,
  output logic             transfer,
  output logic             mode,
  output logic             io_face,
  output logic             safe,
  output logic             wby_sel,
  output logic             wbr_sel,
  output logic [WIR_W-1:0] instr,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             proto_err
);

  // Instruction codes; anything not listed decodes as BYPASS.
  localparam logic [WIR_W-1:0] OP_EXTEST  = WIR_W'(1);
  localparam logic [WIR_W-1:0] OP_INTEST  = WIR_W'(2);
  localparam logic [WIR_W-1:0] OP_SAFE    = WIR_W'(3);
  localparam logic [WIR_W-1:0] OP_PRELOAD = WIR_W'(4);
  localparam logic [WIR_W-1:0] OP_CLAMP   = WIR_W'(5);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURED,
    SHIFTING,
    UPDATED
  } dr_state_t;

  // -------------------------------------------------------------------------
  // Strobe arbitration: capture beats shift beats update. Only the winner
  // acts anywhere in the block, including on the WBR cell controls.
  // -------------------------------------------------------------------------
  logic cap_win;
  logic shf_win;
  logic upd_win;
  logic multi_strobe;

  assign cap_win = capture_wr;
  assign shf_win = shift_wr & ~capture_wr;
  assign upd_win = update_wr & ~capture_wr & ~shift_wr;

  assign multi_strobe = (capture_wr & shift_wr) |
                        (capture_wr & update_wr) |
                        (shift_wr & update_wr);

  // -------------------------------------------------------------------------
  // WIR shift and update stages
  // -------------------------------------------------------------------------
  logic [WIR_W-1:0] wir_stage;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wir_stage <= '0;
    end else if (select_wir) begin
      if (cap_win) begin
        wir_stage <= WIR_W'(1);
      end else if (shf_win) begin
        wir_stage <= {wsi, wir_stage[WIR_W-1:1]};
      end
    end
  end

  // Decode the value about to be loaded so the configuration outputs are
  // registered and change on exactly the same edge as instr.
  logic dec_mode;
  logic dec_io_face;
  logic dec_safe;
  logic dec_wbr_sel;

  always_comb begin
    dec_mode    = 1'b0;
    dec_io_face = 1'b0;
    dec_safe    = 1'b0;
    dec_wbr_sel = 1'b0;
    case (wir_stage)
      OP_EXTEST: begin
        dec_mode    = 1'b1;
        dec_io_face = 1'b1;
        dec_wbr_sel = 1'b1;
      end
      OP_INTEST: begin
        dec_mode    = 1'b1;
        dec_wbr_sel = 1'b1;
      end
      OP_SAFE: begin
        dec_mode = 1'b1;
        dec_safe = 1'b1;
      end
      OP_PRELOAD: begin
        dec_wbr_sel = 1'b1;
      end
      OP_CLAMP: begin
        dec_mode    = 1'b1;
        dec_io_face = 1'b1;
      end
      default: begin
        dec_mode = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      instr   <= '0;
      mode    <= 1'b0;
      io_face <= 1'b0;
      safe    <= 1'b0;
      wbr_sel <= 1'b0;
      wby_sel <= 1'b1;
    end else if (select_wir && upd_win) begin
      instr   <= wir_stage;
      mode    <= dec_mode;
      io_face <= dec_io_face;
      safe    <= dec_safe;
      wbr_sel <= dec_wbr_sel;
      wby_sel <= ~dec_wbr_sel;
    end
  end

  // -------------------------------------------------------------------------
  // Bypass register
  // -------------------------------------------------------------------------
  logic bypass;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      bypass <= 1'b0;
    end else if (!select_wir && wby_sel) begin
      if (cap_win) begin
        bypass <= 1'b0;
      end else if (shf_win) begin
        bypass <= wsi;
      end
    end
  end

  // -------------------------------------------------------------------------
  // WBR cell controls and serial routing
  // -------------------------------------------------------------------------
  logic dr_path;

  assign dr_path  = ~select_wir & wbr_sel;
  assign capture  = dr_path & cap_win;
  assign shift    = dr_path & shf_win;
  assign update   = dr_path & upd_win;
  assign transfer = dr_path & transfer_dr;
  assign wbr_si   = wsi;

  always_comb begin
    wso = wbr_so;
    if (select_wir) begin
      wso = wir_stage[0];
    end else if (wby_sel) begin
      wso = bypass;
    end
  end

  // -------------------------------------------------------------------------
  // Data-register FSM. Any data-register shift or update seen before a first
  // capture (i.e. while still IDLE) is a protocol violation.
  // -------------------------------------------------------------------------
  dr_state_t state;
  dr_state_t state_next;
  logic      fsm_err;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    fsm_err    = 1'b0;
    if (!select_wir) begin
      if (cap_win) begin
        state_next = CAPTURED;
      end else if (shf_win) begin
        state_next = SHIFTING;
        fsm_err    = (state == IDLE);
      end else if (upd_win) begin
        state_next = UPDATED;
        fsm_err    = (state == IDLE);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Shift counter (saturating) and sticky protocol error
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      shift_cnt <= '0;
    end else if (!select_wir) begin
      if (cap_win) begin
        shift_cnt <= '0;
      end else if (shf_win && (shift_cnt != {CNT_W{1'b1}})) begin
        shift_cnt <= shift_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      proto_err <= 1'b0;
    end else if (multi_strobe || fsm_err) begin
      proto_err <= 1'b1;
    end
  end

endmodule

// File: doc/wsp_controller.md
WSP_CONTROLLER -- requirements
Module: wsp_controller

Interface
REQ-001 SHALL have parameter WIR_W, default 3, meaning WIR length in bits (legal values are 3 or greater).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the data-register shift counter.
REQ-003 SHALL have port clk, input, width 1, meaning the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port arst, input, width 1, meaning asynchronous active-high reset.
REQ-005 SHALL have port wsi, input, width 1, meaning wrapper serial input.
REQ-006 SHALL have port select_wir, input, width 1, meaning 1 selects the WIR and 0 selects the data register.
REQ-007 SHALL have ports capture_wr, shift_wr, update_wr, input, width 1 each, meaning the WSP operation strobes.
REQ-008 SHALL have port transfer_dr, input, width 1, meaning the WBR transfer strobe.
REQ-009 SHALL have port wbr_so, input, width 1, meaning the serial return from the boundary-register chain.
REQ-010 SHALL have port wso, output, width 1, meaning wrapper serial output.
REQ-011 SHALL have port wbr_si, output, width 1, meaning serial feed into the boundary-register chain; it SHALL equal wsi.
REQ-012 SHALL have ports capture, shift, update, transfer, output, width 1 each, meaning the WBR cell controls.
REQ-013 SHALL have ports mode, io_face, safe, output, width 1 each, meaning the WBR cell configuration.
REQ-014 SHALL have ports wby_sel and wbr_sel, output, width 1 each, meaning the active data register.
REQ-015 SHALL have port instr, output, width WIR_W, meaning the active (update-stage) instruction.
REQ-016 SHALL have port shift_cnt, output, width CNT_W, meaning the number of data-register shifts since the last capture.
REQ-017 SHALL have port proto_err, output, width 1, meaning a sticky WSP protocol violation flag.

Function
REQ-018 SHALL decode instructions as follows: 0 = BYPASS, 1 = EXTEST, 2 = INTEST, 3 = SAFE, 4 = PRELOAD, 5 = CLAMP; all other codes SHALL decode as BYPASS.
REQ-019 SHALL capture into the WIR shift stage when select_wir and capture_wr are high: the stage loads value 1 (LSB = 1, all other bits 0).
REQ-020 SHALL shift the WIR shift stage when select_wir and shift_wr are high: the stage takes {wsi, stage[WIR_W-1:1]}, so bits shift LSB first.
REQ-021 SHALL load the WIR shift stage into instr when select_wir and update_wr are high; mode, io_face, safe, wby_sel and wbr_sel SHALL change on that same edge.
REQ-022 SHALL produce the decode outputs per instruction as follows:
- mode = 1 for EXTEST, INTEST, SAFE and CLAMP.
- io_face = 1 for EXTEST and CLAMP.
- safe = 1 for SAFE only.
- wbr_sel = 1 for EXTEST, INTEST and PRELOAD.
- wby_sel = NOT wbr_sel.
REQ-023 SHALL drive capture, shift, update and transfer combinationally as (!select_wir AND wbr_sel AND the matching strobe).
REQ-024 SHALL operate the bypass flop only when !select_wir and wby_sel: it SHALL clear to 0 on capture_wr and load wsi on shift_wr.
REQ-025 SHALL drive wso combinationally as follows:
- When select_wir = 1, wso = WIR shift stage bit 0.
- Otherwise, when wby_sel = 1, wso = the bypass flop.
- Otherwise, wso = wbr_so.
REQ-026 SHALL resolve simultaneous strobes with priority capture_wr over shift_wr over update_wr; only the winning strobe acts, including for the outputs in REQ-023.
REQ-027 SHALL set proto_err on any edge where two or more of capture_wr, shift_wr and update_wr are high; proto_err SHALL clear only on reset.
REQ-028 SHALL implement a data-register FSM with states IDLE, CAPTURED, SHIFTING and UPDATED, advancing only when !select_wir:
- capture moves to CAPTURED from any state.
- shift moves to SHIFTING.
- update moves to UPDATED.
- With no strobe, the FSM holds its state.
REQ-029 SHALL set proto_err when shift or update occurs while the FSM is in IDLE.
REQ-030 SHALL clear shift_cnt on a data-register capture, increment it on each data-register shift, and saturate it at all-ones with no wrap-around.
REQ-031 SHALL leave shift_cnt and the FSM unchanged while select_wir = 1.

Reset
REQ-032 SHALL, while arst is high and independent of clk, hold the following values:
- WIR shift stage = 0 and instr = 0 (BYPASS).
- Bypass flop = 0.
- FSM = IDLE.
- shift_cnt = 0 and proto_err = 0.
- mode = io_face = safe = wbr_sel = 0 and wby_sel = 1.
REQ-033 SHALL, when reset asserts mid-shift, abandon any partial WIR content; the first edge after release SHALL behave as from reset.

Verification
REQ-034 SHALL cover this scenario: after reset, instr = 0, wby_sel = 1, and shifting wsi = 1,0,1 with select_wir = 0 gives wso delayed by 1 cycle.
REQ-035 SHALL cover this scenario: WIR capture followed by 3 shifts of wsi = 1,0,0 -> wso = 1,0,0 (captured value); after update, instr = 1, mode = 1, io_face = 1, wbr_sel = 1.
REQ-036 SHALL cover this scenario: with instr = 2 and a data capture followed by 5 shifts -> shift pulses 5 times, shift_cnt = 5, and wso follows wbr_so.
REQ-037 SHALL cover this scenario: loading instr = 7 -> wby_sel = 1, mode = 0, and capture/shift/update stay 0.
REQ-038 SHALL cover this scenario: capture_wr and shift_wr high together -> capture only, and proto_err = 1 and sticky until arst.
REQ-039 SHALL cover this scenario: with CNT_W = 4 and 20 shifts -> shift_cnt = 15 held.
